// File: rtl/tpu_ctrl_pkg.sv
// Shared definitions for the multi-tile systolic-array controller:
// one-hot state bit indices, state width and the skew-drain length helper.
package tpu_ctrl_pkg;

  localparam int STATE_W   = 6;
  localparam int S_IDLE    = 0;
  localparam int S_LOAD    = 1;
  localparam int S_STREAM  = 2;
  localparam int S_TAIL    = 3;
  localparam int S_IMG2COL = 4;
  localparam int S_END     = 5;

  typedef logic [STATE_W-1:0] state_t;

  // Cycles for the last activation to leave an n x n skewed array.
  function automatic int tail_cycles(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/tpu_tile_controller_if.sv
// Host/array-side bundle of the tile controller: start/done, job config,
// param RAM read port, weight-load strobe and activation stream handshake.
interface tpu_tile_controller_if
  import tpu_ctrl_pkg::*;
#(
  parameter int ARR_N  = 8,
  parameter int TILE_W = 8,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) ();

  logic                       start;
  logic [TILE_W-1:0]          cfg_tiles;
  logic [LEN_W-1:0]           cfg_stream_len;
  logic [ADDR_W-1:0]          cfg_param_base;
  logic                       cfg_img2col;
  logic                       busy;
  logic                       done;
  logic [STATE_W-1:0]         curr_state;
  logic [TILE_W-1:0]          tile_idx;
  logic                       param_cs;
  logic [ADDR_W-1:0]          param_addr;
  logic                       w_load;
  logic [$clog2(ARR_N)-1:0]   w_row;
  // Stream handshake: a vector transfers in every cycle where stream_valid
  // and stream_ready are both high at the clock edge; stream_valid never
  // depends on stream_ready and stays high until the transfer happens.
  logic                       stream_valid;
  logic                       stream_ready;
  logic                       drain;
  logic                       img2col_busy;

  modport ctrl (
    input  start, cfg_tiles, cfg_stream_len, cfg_param_base, cfg_img2col, stream_ready,
    output busy, done, curr_state, tile_idx, param_cs, param_addr, w_load, w_row,
           stream_valid, drain, img2col_busy
  );

  modport host (
    output start, cfg_tiles, cfg_stream_len, cfg_param_base, cfg_img2col, stream_ready,
    input  busy, done, curr_state, tile_idx, param_cs, param_addr, w_load, w_row,
           stream_valid, drain, img2col_busy
  );

endinterface

// File: rtl/tpu_param_addr_gen.sv
// Weight-fetch address generator: base + tile*ARR_N + row, plus the
// one-cycle delayed weight-row strobe matching the RAM read latency.
module tpu_param_addr_gen #(
  parameter int ARR_N  = 8,
  parameter int TILE_W = 8,
  parameter int ADDR_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [ADDR_W-1:0]        base,
  input  logic [TILE_W-1:0]        tile,
  input  logic [$clog2(ARR_N):0]   row,
  output logic                     cs,
  output logic [ADDR_W-1:0]        addr,
  output logic                     w_load,
  output logic [$clog2(ARR_N)-1:0] w_row
);

  localparam int RW = $clog2(ARR_N);

  logic [ADDR_W-1:0] tile_off;

  // ARR_N is a power of two, so row < ARR_N is just the top bit clear.
  assign cs       = en && !row[RW];
  assign tile_off = ADDR_W'(tile) << RW;
  assign addr     = cs ? (base + tile_off + ADDR_W'(row)) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_load <= 1'b0;
      w_row  <= '0;
    end else begin
      w_load <= cs;
      w_row  <= cs ? row[RW-1:0] : '0;
    end
  end

endmodule

// File: rtl/tpu_tile_controller.sv
// Multi-tile systolic job sequencer: per tile [IMG2COL] -> LOAD -> STREAM -> TAIL,
// then END. IMG2COL is honoured only when TPU_CTRL_IMG2COL_EN is defined.
module tpu_tile_controller
  import tpu_ctrl_pkg::*;
#(
  parameter int ARR_N  = 8,
  parameter int TILE_W = 8,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  tpu_tile_controller_if.ctrl  bus
);

  localparam int RW    = $clog2(ARR_N);
  localparam int CNT_W = (LEN_W > 8) ? LEN_W : 8;

  localparam logic [STATE_W-1:0] ST_IDLE    = STATE_W'(1) << S_IDLE;
  localparam logic [STATE_W-1:0] ST_LOAD    = STATE_W'(1) << S_LOAD;
  localparam logic [STATE_W-1:0] ST_STREAM  = STATE_W'(1) << S_STREAM;
  localparam logic [STATE_W-1:0] ST_TAIL    = STATE_W'(1) << S_TAIL;
  localparam logic [STATE_W-1:0] ST_IMG2COL = STATE_W'(1) << S_IMG2COL;
  localparam logic [STATE_W-1:0] ST_END     = STATE_W'(1) << S_END;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TILE_W-1:0]  tile_q, tile_d;
  logic [TILE_W-1:0]  tiles_q;
  logic [LEN_W-1:0]   len_q;
  logic [ADDR_W-1:0]  base_q;
  logic               accept;
  logic               i2c_start;
  logic               i2c_tile;

`ifdef TPU_CTRL_IMG2COL_EN
  logic img2col_q;

  always_ff @(posedge clk) begin
    if (rst)         img2col_q <= 1'b0;
    else if (accept) img2col_q <= bus.cfg_img2col;
  end

  assign i2c_start        = bus.cfg_img2col;
  assign i2c_tile         = img2col_q;
  assign bus.img2col_busy = state_q[S_IMG2COL];
`else
  logic unused_cfg_img2col;

  assign unused_cfg_img2col = bus.cfg_img2col;
  assign i2c_start          = 1'b0;
  assign i2c_tile           = 1'b0;
  assign bus.img2col_busy   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tile_d  = tile_q;
    accept  = 1'b0;
    if (!$onehot(state_q)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      tile_d  = '0;
    end else if (state_q[S_IDLE]) begin
      if (bus.start) begin
        accept = 1'b1;
        tile_d = '0;
        cnt_d  = '0;
        if (bus.cfg_tiles == '0) state_d = ST_END;
        else if (i2c_start)      state_d = ST_IMG2COL;
        else                     state_d = ST_LOAD;
      end
    end else if (state_q[S_IMG2COL]) begin
      if (cnt_q == CNT_W'(ARR_N - 1)) begin
        state_d = ST_LOAD;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (state_q[S_LOAD]) begin
      // ARR_N read cycles plus one more to catch the last RAM word.
      if (cnt_q == CNT_W'(ARR_N)) begin
        state_d = ST_STREAM;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (state_q[S_STREAM]) begin
      if (len_q == '0) begin
        state_d = ST_TAIL;
        cnt_d   = '0;
      end else if (bus.stream_ready) begin
        if (cnt_q + CNT_W'(1) == CNT_W'(len_q)) begin
          state_d = ST_TAIL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end else if (state_q[S_TAIL]) begin
      if (cnt_q == CNT_W'(tail_cycles(ARR_N) - 1)) begin
        cnt_d = '0;
        if (tile_q == tiles_q - TILE_W'(1)) begin
          state_d = ST_END;
        end else begin
          tile_d  = tile_q + TILE_W'(1);
          state_d = i2c_tile ? ST_IMG2COL : ST_LOAD;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tile_q  <= '0;
      tiles_q <= '0;
      len_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tile_q  <= tile_d;
      if (accept) begin
        tiles_q <= bus.cfg_tiles;
        len_q   <= bus.cfg_stream_len;
        base_q  <= bus.cfg_param_base;
      end
    end
  end

  tpu_param_addr_gen #(
    .ARR_N  (ARR_N),
    .TILE_W (TILE_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q[S_LOAD]),
    .base   (base_q),
    .tile   (tile_q),
    .row    (cnt_q[RW:0]),
    .cs     (bus.param_cs),
    .addr   (bus.param_addr),
    .w_load (bus.w_load),
    .w_row  (bus.w_row)
  );

  assign bus.busy         = !state_q[S_IDLE];
  assign bus.done         = state_q[S_END];
  assign bus.curr_state   = state_q;
  assign bus.tile_idx     = tile_q;
  assign bus.stream_valid = state_q[S_STREAM] && (len_q != '0);
  assign bus.drain        = state_q[S_TAIL];

endmodule

// File: tb/tb_tpu_tile_controller.sv
// Directed bench for tpu_tile_controller (ARR_N=4); IMG2COL expectations follow
// whether TPU_CTRL_IMG2COL_EN is defined for the build.
module tb_tpu_tile_controller;
  import tpu_ctrl_pkg::*;

  localparam logic [STATE_W-1:0] ST_IDLE   = 6'b000001;
  localparam logic [STATE_W-1:0] ST_LOAD   = 6'b000010;
  localparam logic [STATE_W-1:0] ST_STREAM = 6'b000100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tpu_tile_controller_if #(.ARR_N(4), .TILE_W(8), .ADDR_W(16), .LEN_W(16)) bus ();

  tpu_tile_controller #(.ARR_N(4), .TILE_W(8), .ADDR_W(16), .LEN_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] addr_q[$];
  logic [15:0] exp_q[$];
  int wrow_q[$];
  int tile_seen[$];
  int first_load, first_stream, first_tail, first_wload, cyc_end, cyc_idle;
  int n_done, n_hs, n_valid, n_stream, n_i2c;
  int n_bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] outs_vec();
    return {bus.busy, bus.done, bus.tile_idx, bus.param_cs, bus.param_addr, bus.w_load,
            bus.w_row, bus.stream_valid, bus.drain, bus.img2col_busy};
  endfunction

  // Start a job in the current cycle (cycle 0) and record its trace until IDLE.
  task automatic run_job(input int tiles, input int len, input int base, input bit i2c,
                         input int lo_start, input int lo_len);
    addr_q.delete(); wrow_q.delete(); tile_seen.delete();
    first_load = -1; first_stream = -1; first_tail = -1; first_wload = -1;
    cyc_end = -1; cyc_idle = -1;
    n_done = 0; n_hs = 0; n_valid = 0; n_stream = 0; n_i2c = 0;
    bus.cfg_tiles      = 8'(tiles);
    bus.cfg_stream_len = 16'(len);
    bus.cfg_param_base = 16'(base);
    bus.cfg_img2col    = i2c;
    bus.stream_ready   = 1'b1;
    bus.start          = 1'b1;
    for (int c = 1; c <= 600 && cyc_idle < 0; c++) begin
      step();
      bus.start        = 1'b0;
      bus.stream_ready = !(c >= lo_start && c < lo_start + lo_len);
      if (!$onehot(bus.curr_state)) n_bad++;
      if (bus.curr_state[S_LOAD] && first_load < 0) first_load = c;
      if (bus.curr_state[S_STREAM] && first_stream < 0) first_stream = c;
      if (bus.curr_state[S_TAIL] && first_tail < 0) first_tail = c;
      if (bus.curr_state[S_STREAM]) n_stream++;
      if (bus.param_cs) addr_q.push_back(bus.param_addr);
      if (bus.w_load) begin
        wrow_q.push_back(int'(bus.w_row));
        if (first_wload < 0) first_wload = c;
      end
      if (bus.stream_valid) n_valid++;
      if (bus.stream_valid && bus.stream_ready) n_hs++;
      if (bus.img2col_busy) n_i2c++;
      if (bus.busy && (tile_seen.size() == 0 || tile_seen[$] != int'(bus.tile_idx)))
        tile_seen.push_back(int'(bus.tile_idx));
      if (bus.done) begin
        n_done++;
        if (cyc_end < 0) cyc_end = c;
      end
      if (bus.curr_state == ST_IDLE) cyc_idle = c;
    end
    if (cyc_idle < 0) begin
      checks++; errors++;
      $display("FAIL job_timeout: got no return to IDLE within 600 cycles, required IDLE");
    end
  endtask

  task automatic test_reset();
    bus.start = 0; bus.cfg_tiles = 0; bus.cfg_stream_len = 0; bus.cfg_param_base = 0;
    bus.cfg_img2col = 0; bus.stream_ready = 0;
    rst = 1'b1;
    step(); step();
    checks++; if (bus.curr_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %b exp %b", bus.curr_state, ST_IDLE); end
    checks++; if (outs_vec() !== 33'd0) begin errors++; $display("FAIL reset_outs: got %h exp 0", outs_vec()); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_tile();
    run_job(1, 3, 'h100, 1'b0, 0, 0);
    checks++; if (first_load !== 1) begin errors++; $display("FAIL single_load_start: got %0d exp 1", first_load); end
    checks++; if (first_wload !== 2) begin errors++; $display("FAIL single_wload_start: got %0d exp 2", first_wload); end
    checks++; if (first_stream !== 6) begin errors++; $display("FAIL single_stream_start: got %0d exp 6", first_stream); end
    checks++; if (first_tail !== 9) begin errors++; $display("FAIL single_tail_start: got %0d exp 9", first_tail); end
    checks++; if (cyc_end !== 16) begin errors++; $display("FAIL single_done_cycle: got %0d exp 16", cyc_end); end
    checks++; if (cyc_idle !== 17) begin errors++; $display("FAIL single_idle_cycle: got %0d exp 17", cyc_idle); end
    checks++; if (n_hs !== 3) begin errors++; $display("FAIL single_handshakes: got %0d exp 3", n_hs); end
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(16'h0100 + 16'(i));
    checks++; if (addr_q.size() !== exp_q.size()) begin errors++; $display("FAIL single_addr_count: got %0d exp %0d", addr_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < addr_q.size(); i++) begin
      checks++; if (addr_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_addr[%0d]: got %h exp %h", i, addr_q[i], exp_q[i]); end
    end
    checks++; if (wrow_q.size() !== 4) begin errors++; $display("FAIL single_wrow_count: got %0d exp 4", wrow_q.size()); end
    for (int i = 0; i < wrow_q.size() && i < 4; i++) begin
      checks++; if (wrow_q[i] !== i) begin errors++; $display("FAIL single_wrow[%0d]: got %0d exp %0d", i, wrow_q[i], i); end
    end
  endtask

  task automatic test_multi_tile();
    run_job(3, 2, 'h0, 1'b0, 0, 0);
    exp_q.delete();
    for (int i = 0; i < 12; i++) exp_q.push_back(16'(i));
    checks++; if (addr_q.size() !== exp_q.size()) begin errors++; $display("FAIL multi_addr_count: got %0d exp %0d", addr_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < addr_q.size(); i++) begin
      checks++; if (addr_q[i] !== exp_q[i]) begin errors++; $display("FAIL multi_addr[%0d]: got %h exp %h", i, addr_q[i], exp_q[i]); end
    end
    checks++; if (tile_seen.size() !== 3) begin errors++; $display("FAIL multi_tile_count: got %0d exp 3", tile_seen.size()); end
    for (int i = 0; i < tile_seen.size() && i < 3; i++) begin
      checks++; if (tile_seen[i] !== i) begin errors++; $display("FAIL multi_tile_idx[%0d]: got %0d exp %0d", i, tile_seen[i], i); end
    end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL multi_done_pulses: got %0d exp 1", n_done); end
    checks++; if (cyc_end !== 43) begin errors++; $display("FAIL multi_done_cycle: got %0d exp 43", cyc_end); end
  endtask

  task automatic test_backpressure();
    run_job(1, 2, 'h20, 1'b0, 7, 5);
    checks++; if (n_stream !== 7) begin errors++; $display("FAIL bp_stream_cycles: got %0d exp 7", n_stream); end
    checks++; if (n_hs !== 2) begin errors++; $display("FAIL bp_handshakes: got %0d exp 2", n_hs); end
    checks++; if (first_tail !== 13) begin errors++; $display("FAIL bp_tail_start: got %0d exp 13", first_tail); end
    checks++; if (cyc_end !== 20) begin errors++; $display("FAIL bp_done_cycle: got %0d exp 20", cyc_end); end
  endtask

  task automatic test_zero_tiles();
    run_job(0, 3, 'h100, 1'b0, 0, 0);
    checks++; if (cyc_end !== 1) begin errors++; $display("FAIL zt_done_cycle: got %0d exp 1", cyc_end); end
    checks++; if (cyc_idle !== 2) begin errors++; $display("FAIL zt_idle_cycle: got %0d exp 2", cyc_idle); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL zt_done_pulses: got %0d exp 1", n_done); end
    checks++; if (addr_q.size() !== 0) begin errors++; $display("FAIL zt_param_reads: got %0d exp 0", addr_q.size()); end
  endtask

  task automatic test_zero_len();
    run_job(1, 0, 'h0, 1'b0, 0, 0);
    checks++; if (n_stream !== 1) begin errors++; $display("FAIL zl_stream_cycles: got %0d exp 1", n_stream); end
    checks++; if (n_valid !== 0) begin errors++; $display("FAIL zl_stream_valid: got %0d exp 0", n_valid); end
    checks++; if (first_tail !== 7) begin errors++; $display("FAIL zl_tail_start: got %0d exp 7", first_tail); end
    checks++; if (cyc_end !== 14) begin errors++; $display("FAIL zl_done_cycle: got %0d exp 14", cyc_end); end
  endtask

  task automatic test_addr_wrap();
    run_job(1, 1, 'hFFFE, 1'b0, 0, 0);
    exp_q.delete();
    exp_q.push_back(16'hFFFE); exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0001);
    checks++; if (addr_q.size() !== exp_q.size()) begin errors++; $display("FAIL wrap_addr_count: got %0d exp %0d", addr_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < addr_q.size(); i++) begin
      checks++; if (addr_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_addr[%0d]: got %h exp %h", i, addr_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_stream();
    int late_done = 0;
    bus.cfg_tiles = 8'd2; bus.cfg_stream_len = 16'd3; bus.cfg_param_base = 16'h0040;
    bus.cfg_img2col = 1'b0; bus.stream_ready = 1'b1; bus.start = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      step();
      // A start with a different tile count while busy must be ignored.
      bus.start     = (c == 7);
      bus.cfg_tiles = (c == 7) ? 8'd1 : 8'd2;
      if (c == 16) begin
        checks++; if (bus.tile_idx !== 8'd1) begin errors++; $display("FAIL rst_tile1_idx: got %0d exp 1", bus.tile_idx); end
        checks++; if (bus.param_addr !== 16'h0044 || bus.param_cs !== 1'b1) begin errors++; $display("FAIL rst_tile1_addr: got cs=%b %h exp cs=1 0044", bus.param_cs, bus.param_addr); end
      end
    end
    checks++; if (bus.curr_state !== ST_STREAM) begin errors++; $display("FAIL rst_pre_state: got %b exp %b", bus.curr_state, ST_STREAM); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.curr_state !== ST_IDLE) begin errors++; $display("FAIL rst_mid_state: got %b exp %b", bus.curr_state, ST_IDLE); end
    checks++; if (outs_vec() !== 33'd0) begin errors++; $display("FAIL rst_mid_outs: got %h exp 0", outs_vec()); end
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.done || bus.curr_state !== ST_IDLE) late_done++;
    end
    checks++; if (late_done !== 0) begin errors++; $display("FAIL rst_no_done: got %0d active cycles exp 0", late_done); end
  endtask

  task automatic test_img2col();
    int exp_i2c, exp_load, exp_end;
`ifdef TPU_CTRL_IMG2COL_EN
    exp_i2c = 8; exp_load = 5; exp_end = 35;
`else
    exp_i2c = 0; exp_load = 1; exp_end = 27;
`endif
    run_job(2, 1, 'h0, 1'b1, 0, 0);
    checks++; if (n_i2c !== exp_i2c) begin errors++; $display("FAIL i2c_busy_cycles: got %0d exp %0d", n_i2c, exp_i2c); end
    checks++; if (first_load !== exp_load) begin errors++; $display("FAIL i2c_load_start: got %0d exp %0d", first_load, exp_load); end
    checks++; if (cyc_end !== exp_end) begin errors++; $display("FAIL i2c_done_cycle: got %0d exp %0d", cyc_end, exp_end); end
    checks++; if (addr_q.size() !== 8) begin errors++; $display("FAIL i2c_addr_count: got %0d exp 8", addr_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_backpressure();
    test_zero_tiles();
    test_zero_len();
    test_addr_wrap();
    test_reset_mid_stream();
    test_img2col();
    checks++; if (n_bad !== 0) begin errors++; $display("FAIL onehot_state: got %0d bad cycles exp 0", n_bad); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tpu_tile_controller.md
Name: tpu_tile_controller

Overview:
- Parametrised successor to the single-shot accelerator controller.
- Sequences a multi-tile systolic-array job per tile: LOAD (weight rows fetched from the param single-port RAM), STREAM (activation vectors with backpressure), TAIL (skew drain). After the last tile it goes to END.
- Exposes a one-hot state vector, a start/done handshake, and an optional IMG2COL phase.
- Sits between the host/CSR block and the array, param RAM and input FIFO.

Parameters:
- ARR_N, 8: systolic array dimension (rows = cols); power of two, 2..64.
- TILE_W, 8: width of the tile count and tile index.
- ADDR_W, 16: param RAM address width.
- LEN_W, 16: width of the per-tile stream length.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  job start request; sampled only in IDLE
- cfg_tiles  in  TILE_W  number of tiles; latched on accepted start
- cfg_stream_len  in  LEN_W  activation vectors per tile; latched
- cfg_param_base  in  ADDR_W  weight base address; latched
- cfg_img2col  in  1  request IMG2COL phase; latched
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, high exactly while in END
- curr_state  out  STATE_W  one-hot state
- tile_idx  out  TILE_W  current tile, 0-based
- param_cs  out  1  param RAM read enable
- param_addr  out  ADDR_W  param RAM address
- w_load  out  1  weight row valid into array; param_cs delayed 1 cycle
- w_row  out  $clog2(ARR_N)  row index for w_load
- stream_valid  out  1  controller requests an activation vector
- stream_ready  in  1  input FIFO has a vector
- drain  out  1  high in TAIL
- img2col_busy  out  1  high in IMG2COL

Behaviour:
- Reset (rst=1 at an edge): next cycle curr_state = 1<<S_IDLE; all other outputs and counters 0. Applies mid-operation with no completion pulse.
- IDLE:
  - start=1 latches all cfg_* and sets tile_idx=0.
  - If cfg_tiles==0, go to END; otherwise go to IMG2COL when taken, else LOAD.
  - start outside IDLE is ignored.
- IMG2COL (taken only with macro and cfg_img2col=1): lasts exactly ARR_N cycles with img2col_busy=1, then LOAD. Entered at the start of every tile.
- LOAD: lasts ARR_N+1 cycles.
  - Cycles 0..ARR_N-1: param_cs=1, param_addr = base + tile_idx*ARR_N + row (row = cycle), computed modulo 2^ADDR_W.
  - Cycles 1..ARR_N: w_load=1, w_row = row-1 (RAM read latency 1).
  - Then STREAM.
- STREAM:
  - stream_valid=1; the counter increments on stream_valid && stream_ready.
  - After cfg_stream_len handshakes, go to TAIL in the cycle following the last handshake.
  - stream_len==0: the single STREAM cycle has stream_valid=0, then TAIL.
  - stream_ready low holds the state indefinitely.
- TAIL: drain=1 for exactly 2*ARR_N-1 cycles.
  - If tile_idx == tiles-1, go to END.
  - Otherwise tile_idx+1, then IMG2COL or LOAD.
- END: done=1 for one cycle, then IDLE. start in the END cycle is ignored.
- Exactly one curr_state bit is high at all times; an illegal encoding recovers to IDLE next cycle.
- All outputs are registered or decoded from registered state; no combinational path from stream_ready to any output other than the counter.

Optional Feature:
- TPU_CTRL_IMG2COL_EN defined: cfg_img2col honoured; the IMG2COL state is reachable as above.
- Undefined: cfg_img2col ignored; the IMG2COL state is unreachable; img2col_busy is tied 0.
- The state encoding and port list are identical in both builds.

Decomposition:
- Package tpu_ctrl_pkg holds:
  - state bit indices S_IDLE, S_LOAD, S_STREAM, S_TAIL, S_IMG2COL, S_END;
  - STATE_W=6;
  - function tail_cycles(n)=2n-1.
- Sub-module tpu_param_addr_gen (base, tile, row -> addr, cs, 1-cycle w_load/w_row delay) instantiated in LOAD.

Test Plan (ARR_N=4 unless stated):
- Single tile: start at cycle 0 with tiles=1, len=3, base=0x100, stream_ready=1.
  - LOAD cycles 1-5 reading addresses 0x100-0x103; w_load in cycles 2-5.
  - STREAM cycles 6-8; TAIL cycles 9-15; done=1 at cycle 16; IDLE at cycle 17.
- Multi-tile: tiles=3, base=0x0 -> reads 0x0-0x3, 0x4-0x7, 0x8-0xB; tile_idx 0,1,2; exactly one done pulse.
- Backpressure: len=2, stream_ready low 5 cycles mid-STREAM -> STREAM extends by 5 cycles; exactly 2 handshakes counted.
- Edge cases:
  - tiles=0 -> IDLE, END, IDLE with done for 1 cycle and no param_cs.
  - len=0 -> single STREAM cycle with stream_valid=0.
  - base=0xFFFE -> addresses wrap to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset mid-STREAM of tile 1: rst=1 -> IDLE next cycle with all outputs 0 and no done. A start while busy has no effect.
- Macro build, cfg_img2col=1, tiles=2 -> img2col_busy for 4 cycles before each LOAD. In the non-macro build the same stimulus never asserts img2col_busy.
